seg_scan_blink: RTL
===================

Name: seg_scan_blink

Overview:
- Display-side stage directly downstream of the mm:ss BCD counter.
- Snapshots the four BCD digits once per scan frame and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Blanks the digit pair being adjusted at a blink rate derived from the scan clock; optionally blanks a leading minutes-tens zero.
- All outputs are registered and drive the board pins directly.

Parameters:
- BLINK_DIV, 6, number of scan ticks per blink half-period (50 Hz / 12 gives ~4.2 Hz on/off); legal range 2..255.

Ports:
- clk50hz  in  1  scan clock; one digit advance per rising edge.
- reset  in  1  synchronous, active-high; clock clk50hz.
- sec_one  in  4  BCD seconds units.
- sec_ten  in  4  BCD seconds tens.
- min_one  in  4  BCD minutes units.
- min_ten  in  4  BCD minutes tens.
- adjust_en  in  1  1 = adjust mode; the selected pair blinks.
- adjust_sel  in  1  0 = blink seconds pair (digits 0,1); 1 = blink minutes pair (digits 2,3).
- lz_blank  in  1  1 = blank digit 3 when the snapshot of min_ten is 0.
- anode  out  4  active-low digit enables; anode[0]=sec_one … anode[3]=min_ten.
- cathode  out  7  active-low segments; cathode[0]=a … cathode[6]=g.
- frame_start  out  1  one-cycle pulse, coincident with digit 0 being driven.

Behaviour:
- Reset values: scan_idx=0, snapshot regs=0, blink_cnt=0, blink_phase=0, anode=4'hF, cathode=7'h7F, frame_start=0.
- scan_idx is a 2-bit counter, +1 per edge, wrapping 3→0.
- Snapshot: on the edge where scan_idx==3, all four inputs are captured. The next frame (idx 0..3) displays only the captured values, so no tearing occurs within a frame. Input changes take effect at the next frame boundary, at most 4 cycles later.
- Output register: each edge loads the outputs for digit i = the pre-edge value of scan_idx.
  - Visible digit: anode <= ~(4'b0001 << i); cathode <= decode(snap[i]).
  - Blanked digit: anode <= 4'hF; cathode <= 7'h7F.
  - frame_start <= (i==0).
  - Latency: one cycle from scan_idx to pins.
- Decode, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10..15 display a dash (0111111).
- Blanking conditions (OR):
  - (a) adjust_en && blink_phase && (adjust_sel ? i>=2 : i<=1).
  - (b) lz_blank && i==3 && snap_min_ten==0.
- Blink timer:
  - While adjust_en=0: blink_cnt=0 and blink_phase=0, forced synchronously.
  - While adjust_en=1: blink_cnt increments each edge. At BLINK_DIV-1 it wraps to 0 and toggles blink_phase.
  - Entering adjust therefore always starts with a full visible half-period of BLINK_DIV cycles.
- adjust_sel changing mid-blink does not restart the timer; the newly selected pair follows the current phase on the next digit.
- Reset asserted mid-frame: outputs blank on the next edge and scanning restarts at digit 0. The snapshot is 0 until the first idx-3 edge after release, so the first frame shows "00:00" (or digit 3 blanked if lz_blank=1).
- All anodes are never active simultaneously; at most one anode bit is 0 in any cycle.

Test Plan:
- Reset held 3 cycles, then released with inputs 1,2,3,4 (min_ten..sec_one) → during reset anode=F, cathode=7F. The first frame shows 0s on anode E,D,B,7 in sequence. From frame 2: anode E/cathode 0011001 (4), D/0110000 (3), B/0100100 (2), 7/1111001 (1). frame_start is high with each anode=E.
- sec_one changed from 4 to 5 while digit 2 is being driven → the current frame still shows 4 on digit 0 of that frame. The next frame shows 0010010 on anode E.
- adjust_en=1, adjust_sel=0, BLINK_DIV=6 → for 6 cycles all digits are visible. For the next 6 cycles, the slots for digits 0 and 1 show anode=F/cathode=7F while digits 2 and 3 remain visible. The pattern repeats; with adjust_sel=1, digits 2 and 3 blank instead.
- Deassert adjust_en during a blanked phase → the next edge shows all digits visible. Reasserting it gives a full 6 visible cycles before the first blank.
- lz_blank=1 with min_ten=0, then min_ten=1 → the digit 3 slot is anode=F while the value is 0. After the next snapshot, anode=7 with cathode=1111001.
- sec_one=4'hC → the digit 0 slot shows cathode=0111111 (dash); the other digits are unaffected.

Source files
------------

// File: rtl/seg_scan_blink_if.sv
// Bus between the mm:ss BCD counter and the display scan stage: four BCD
// digits plus the adjust/blanking controls in one direction, and the
// registered pin drives (anode, cathode, frame_start) in the other.
interface seg_scan_blink_if;
    logic [3:0] sec_one;
    logic [3:0] sec_ten;
    logic [3:0] min_one;
    logic [3:0] min_ten;
    logic       adjust_en;
    logic       adjust_sel;
    logic       lz_blank;
    logic [3:0] anode;
    logic [6:0] cathode;
    logic       frame_start;

    // Counter side: supplies digits and controls, observes the pins.
    modport master (
        output sec_one, sec_ten, min_one, min_ten,
        output adjust_en, adjust_sel, lz_blank,
        input  anode, cathode, frame_start
    );

    // Display stage: consumes digits and controls, drives the pins.
    modport slave (
        input  sec_one, sec_ten, min_one, min_ten,
        input  adjust_en, adjust_sel, lz_blank,
        output anode, cathode, frame_start
    );
endinterface

// File: rtl/seg_scan_blink.sv
// 4-digit common-anode 7-segment scanner. Snapshots the mm:ss BCD digits once
// per scan frame, drives one digit per clk50hz edge, blinks the pair under
// adjustment and optionally blanks a leading minutes-tens zero. All pin
// drives come straight from registers.
module seg_scan_blink #(
    parameter int BLINK_DIV = 6     // scan ticks per blink half-period, 2..255
) (
    input  logic              clk50hz,
    input  logic              reset,
    seg_scan_blink_if.slave   disp
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);
    localparam logic [3:0] ANODE_OFF  = 4'hF;
    localparam logic [6:0] SEG_OFF    = 7'h7F;

    // Scan position and frame snapshot (index 0 = sec_one ... 3 = min_ten).
    logic [1:0] scan_idx_q;
    logic [1:0] scan_idx_d;
    logic [3:0] snap_q    [4];
    logic [3:0] digit_in  [4];

    // Blink timer.
    logic [7:0] blink_cnt_q;
    logic [7:0] blink_cnt_d;
    logic       blink_phase_q;
    logic       blink_phase_d;

    // Pin registers.
    logic [3:0] anode_q;
    logic [3:0] anode_d;
    logic [6:0] cathode_q;
    logic [6:0] cathode_d;
    logic       frame_start_q;
    logic       frame_start_d;

    // Per-digit blanking requests, selected by scan index.
    logic [3:0] blank_blink_vec;
    logic [3:0] blank_lz_vec;

    logic [3:0] cur_digit;
    logic [6:0] cur_seg;
    logic       cur_blank;

    // Active-low {g..a} pattern for a BCD code; non-decimal codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    assign digit_in[0] = disp.sec_one;
    assign digit_in[1] = disp.sec_ten;
    assign digit_in[2] = disp.min_one;
    assign digit_in[3] = disp.min_ten;

    // Per-digit blank decisions. Digits 0,1 form the seconds pair and
    // digits 2,3 the minutes pair; only digit 3 can carry a leading zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit_blank
            localparam logic IS_MIN_PAIR = (gi >= 2);
            assign blank_blink_vec[gi] = disp.adjust_en && blink_phase_q
                                         && (disp.adjust_sel == IS_MIN_PAIR);
            if (gi == 3) begin : g_lz
                assign blank_lz_vec[gi] = disp.lz_blank && (snap_q[gi] == 4'd0);
            end else begin : g_no_lz
                assign blank_lz_vec[gi] = 1'b0;
            end
        end
    endgenerate

    // Next pin values for the digit currently addressed by scan_idx_q.
    always_comb begin
        cur_digit     = snap_q[scan_idx_q];
        cur_seg       = seg_decode(cur_digit);
        cur_blank     = blank_blink_vec[scan_idx_q] | blank_lz_vec[scan_idx_q];
        anode_d       = cur_blank ? ANODE_OFF : ~(4'b0001 << scan_idx_q);
        cathode_d     = cur_blank ? SEG_OFF : cur_seg;
        frame_start_d = (scan_idx_q == 2'd0);
        scan_idx_d    = scan_idx_q + 2'd1;
    end

    // Blink timer next state: held at zero outside adjust mode so entering
    // adjust always starts with a full visible half-period.
    always_comb begin
        blink_cnt_d   = 8'd0;
        blink_phase_d = 1'b0;
        if (disp.adjust_en) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = 8'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 8'd1;
                blink_phase_d = blink_phase_q;
            end
        end
    end

    // Scan counter, blink timer and pin registers.
    always_ff @(posedge clk50hz) begin
        if (reset) begin
            scan_idx_q    <= 2'd0;
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
            anode_q       <= ANODE_OFF;
            cathode_q     <= SEG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            scan_idx_q    <= scan_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            anode_q       <= anode_d;
            cathode_q     <= cathode_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Snapshot all four digits on the last slot of a frame, so the next
    // frame is drawn from one consistent set of values.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_snap
            always_ff @(posedge clk50hz) begin
                if (reset) begin
                    snap_q[gi] <= 4'd0;
                end else if (scan_idx_q == 2'd3) begin
                    snap_q[gi] <= digit_in[gi];
                end
            end
        end
    endgenerate

    assign disp.anode       = anode_q;
    assign disp.cathode     = cathode_q;
    assign disp.frame_start = frame_start_q;

endmodule
